// File: rtl/dec_arb_pkg.sv
// Shared definitions for the decimal key arbiter / BCD encoder front-end.
//   NUM_KEYS, BCD_W : fixed geometry (10 keys, 4-bit BCD)
//   state_t         : sequencing FSM states
//   onehot_to_bcd   : one-hot key vector -> BCD digit
package dec_arb_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // OR of the indices of all set bits; exact for a one-hot input, and
  // an all-zero input maps to digit 0.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] oh);
    logic [BCD_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (oh[i]) b = b | BCD_W'(i);
    return b;
  endfunction

endpackage

// File: rtl/dec_bcd_enc.sv
// Combinational 10-bit one-hot to 4-bit BCD encoder.
//   onehot : one-hot digit select (bit i = digit i)
//   bcd    : BCD code of the selected digit
module dec_bcd_enc
  import dec_arb_pkg::*;
(
  input  logic [NUM_KEYS-1:0] onehot,
  output logic [BCD_W-1:0]    bcd
);

  assign bcd = onehot_to_bcd(onehot);

endmodule

// File: rtl/dec_key_arb.sv
// Keypad sequencing front-end: synchronise 10 key lines, pick one key,
// debounce it, and hand its BCD code to a consumer over valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   key        : raw asynchronous key lines (bit i = digit i pressed)
//   ready      : consumer accepts bcd when valid && ready
//   valid      : bcd holds an accepted digit
//   bcd        : BCD code of the granted digit
//   multi      : more than one key was high when the grant was captured
//   busy       : FSM is not in IDLE
// Optional build macro DEC_ARB_RR_EN: round-robin arbitration instead of
// fixed lowest-index priority.
module dec_key_arb
  import dec_arb_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                ready,
  output logic                valid,
  output logic [BCD_W-1:0]    bcd,
  output logic                multi,
  output logic                busy
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 1);

  // two-flop synchroniser
  logic [NUM_KEYS-1:0] ks_meta, ks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_meta <= '0;
      ks      <= '0;
    end else begin
      ks_meta <= key;
      ks      <= ks_meta;
    end
  end

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_KEYS-1:0] grant, grant_nxt;
  logic [BCD_W-1:0]    bcd_nxt;
  logic                multi_nxt;
  logic [NUM_KEYS-1:0] sel_oh;
  logic [BCD_W-1:0]    grant_bcd;
  logic                hs;

  dec_bcd_enc u_enc (
    .onehot (grant),
    .bcd    (grant_bcd)
  );

  assign valid = (state == PRESENT);
  assign busy  = (state != IDLE);
  assign hs    = valid && ready;

`ifdef DEC_ARB_RR_EN
  // Round-robin: search starts just after the last handed-off digit.
  logic [BCD_W-1:0] ptr;
  logic [BCD_W-1:0] start;

  function automatic logic [NUM_KEYS-1:0] rr_pick(input logic [NUM_KEYS-1:0] req,
                                                  input logic [BCD_W-1:0]    first);
    logic [NUM_KEYS-1:0] g;
    logic [BCD_W:0]      s;
    logic                found;
    g     = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_KEYS; off++) begin
      s = {1'b0, first} + (BCD_W+1)'(off);
      if (s >= (BCD_W+1)'(NUM_KEYS)) s = s - (BCD_W+1)'(NUM_KEYS);
      if (!found && req[s[BCD_W-1:0]]) begin
        g[s[BCD_W-1:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return g;
  endfunction

  assign start  = (ptr == BCD_W'(NUM_KEYS - 1)) ? '0 : ptr + 1'b1;
  assign sel_oh = rr_pick(ks, start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= BCD_W'(NUM_KEYS - 1);
    else if (hs) ptr <= grant_bcd;
  end
`else
  // Fixed priority: isolate the lowest set bit.
  assign sel_oh = ks & (~ks + 1'b1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      grant <= '0;
      bcd   <= '0;
      multi <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      grant <= grant_nxt;
      bcd   <= bcd_nxt;
      multi <= multi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    bcd_nxt   = bcd;
    multi_nxt = multi;
    unique case (state)
      IDLE: begin
        if (|ks) begin
          grant_nxt = sel_oh;
          // x & (x-1) is non-zero iff more than one bit is set
          multi_nxt = |(ks & (ks - 1'b1));
          cnt_nxt   = CNT_LOAD;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!(|(ks & grant))) begin
          multi_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          bcd_nxt   = grant_bcd;
          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PRESENT: begin
        if (ready) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!(|(ks & grant))) begin
          multi_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dec_key_arb.sv
// Scoreboard bench for dec_key_arb (DEBOUNCE_CYC=4). Stimulus pushes the
// expected {bcd, multi} of each digit; the monitor pops on every handshake.
module tb_dec_key_arb;
  import dec_arb_pkg::*;

  typedef struct packed {
    logic [3:0] bcd;
    logic       multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key = '0;
  logic       ready = 1'b0;
  logic       valid;
  logic [3:0] bcd;
  logic       multi;
  logic       busy;

  int   cmp = 0;
  int   err = 0;
  exp_t sb[$];

  dec_key_arb #(.DEBOUNCE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .ready (ready),
    .valid (valid),
    .bcd   (bcd),
    .multi (multi),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    cmp++;
    if (got !== want) begin
      err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // monitor: every handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        cmp++;
        err++;
        $display("FAIL unexpected_valid got bcd=%0d want none t=%0t", bcd, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_bcd", 32'(bcd), 32'(e.bcd));
        chk("hs_multi", 32'(multi), 32'(e.multi));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget && sb.size() != 0; i++) step(1);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) step(1);
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i;
    @(negedge clk);
    for (i = 0; i < budget && !valid; i++) @(negedge clk);
    chk(name, 32'(valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bcd",   32'(bcd),   32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    #10 rst_n = 1'b1;
    step(2);

    // T1: digit 3, latency check: valid first seen after edge 7
    key = 10'h008; ready = 1'b1;
    sb.push_back('{bcd: 4'd3, multi: 1'b0});
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t1_valid_e6", 32'(valid), 32'd0);
    chk("t1_busy_e6",  32'(busy),  32'd1);
    @(negedge clk);
    chk("t1_valid_e7", 32'(valid), 32'd1);
    step(3);
    chk("t1_rel_valid", 32'(valid), 32'd0);
    chk("t1_rel_busy",  32'(busy),  32'd1);
    chk("t1_bcd_hold",  32'(bcd),   32'd3);
    key = '0;
    wait_idle("t1_idle", 10);
    step(4);

    // T2: 2-cycle bounce on key 5 is rejected
    key = 10'h020;
    step(2);
    key = '0;
    step(12);
    chk("t2_busy",  32'(busy),  32'd0);
    chk("t2_valid", 32'(valid), 32'd0);

    // T3: digits 2 and 7 together: 2 first with multi, then 7 alone
    key = 10'h084;
    sb.push_back('{bcd: 4'd2, multi: 1'b1});
    wait_drain("t3_first", 20);
    sb.push_back('{bcd: 4'd7, multi: 1'b0});
    key = 10'h080;
    wait_drain("t3_second", 20);
    key = '0;
    wait_idle("t3_idle", 10);
    chk("t3_multi_clr", 32'(multi), 32'd0);

    // T4: digit 9 with consumer stalled for 10 cycles
    ready = 1'b0;
    key = 10'h200;
    wait_valid("t4_valid", 20);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(valid), 32'd1);
      chk("t4_hold_bcd",   32'(bcd),   32'd9);
      @(negedge clk);
    end
    sb.push_back('{bcd: 4'd9, multi: 1'b0});
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_drop", 32'(valid), 32'd0);
    chk("t4_drain", 32'(sb.size()), 32'd0);
    key = '0;
    wait_idle("t4_idle", 10);

    // T5: asynchronous reset while presenting digit 4
    ready = 1'b0;
    key = 10'h010;
    wait_valid("t5_valid", 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_bcd",   32'(bcd),   32'd0);
    chk("t5_rst_multi", 32'(multi), 32'd0);
    chk("t5_rst_busy",  32'(busy),  32'd0);
    key = '0;
    step(2);
    rst_n = 1'b1;
    ready = 1'b1;
    step(12);
    chk("t5_post_busy", 32'(busy), 32'd0);
    sb.push_back('{bcd: 4'd4, multi: 1'b0});
    key = 10'h010;
    wait_drain("t5_new", 20);
    key = '0;
    wait_idle("t5_idle", 10);

    // T6: keys 0 and 1 held; key 0 dropped for one cycle after handoff
    key = 10'h003;
    sb.push_back('{bcd: 4'd0, multi: 1'b1});
    wait_drain("t6_first", 20);
`ifdef DEC_ARB_RR_EN
    sb.push_back('{bcd: 4'd1, multi: 1'b1});
`else
    sb.push_back('{bcd: 4'd0, multi: 1'b1});
`endif
    key = 10'h002;
    step(1);
    key = 10'h003;
    wait_drain("t6_second", 20);
    key = '0;
    wait_idle("t6_idle", 10);

    step(5);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
